// File: rtl/motor_ramp_pwm.sv
// Motor drive stage: slews the applied duty one step per ramp tick toward the
// requested speed code and emits a period-aligned PWM with an emergency-stop latch.
module motor_ramp_pwm #(
    parameter int unsigned SLOT_CYCLES = 4096,
    parameter int unsigned RAMP_CYCLES = 2**20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] target,
    input  logic       enable,
    input  logic       estop,
    output logic       motor_pwm,
    output logic [3:0] duty_now,
    output logic       at_target,
    output logic       busy,
    output logic       fault
);

    localparam int unsigned SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_MAX = SW'(SLOT_CYCLES - 1);
    localparam logic [RW-1:0] RAMP_MAX = RW'(RAMP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_RAMP_DOWN,
        S_HOLD,
        S_STOP
    } state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_duty, w_duty_next;
    logic [3:0]    w_eff;
    logic [RW-1:0] r_ramp_cnt;
    logic          w_tick, w_clr_ramp;
    logic [SW-1:0] r_slot_div;
    logic [3:0]    r_slot;
    logic [3:0]    r_duty_lat;
    logic          r_pwm;
    logic          r_at_target, r_busy, r_fault;
    logic          w_div_wrap, w_period_end;
    logic          w_static, w_next_ramp;

    assign w_eff        = enable ? target : 4'd0;
    assign w_tick       = (r_ramp_cnt == RAMP_MAX);
    assign w_div_wrap   = (r_slot_div == SLOT_MAX);
    assign w_period_end = w_div_wrap && (r_slot == 4'd14);
    assign w_static     = (r_state == S_IDLE) || (r_state == S_HOLD) || (r_state == S_STOP);
    assign w_next_ramp  = (w_next == S_RAMP_UP) || (w_next == S_RAMP_DOWN);
    // Reversals keep the running tick phase; only leaving a static state restarts it.
    assign w_clr_ramp   = w_static && w_next_ramp;

    always_comb begin
        w_next      = r_state;
        w_duty_next = r_duty;
        if (estop) begin
            w_next      = S_STOP;
            w_duty_next = 4'd0;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_eff != 4'd0) w_next = S_RAMP_UP;
                S_RAMP_UP: begin
                    if (w_eff == r_duty)      w_next = S_HOLD;
                    else if (w_eff < r_duty)  w_next = S_RAMP_DOWN;
                    else if (w_tick && r_duty != 4'd15) w_duty_next = r_duty + 4'd1;
                end
                S_RAMP_DOWN: begin
                    if (w_eff == r_duty)      w_next = (w_eff != 4'd0) ? S_HOLD : S_IDLE;
                    else if (w_eff > r_duty)  w_next = S_RAMP_UP;
                    else if (w_tick && r_duty != 4'd0) w_duty_next = r_duty - 4'd1;
                end
                S_HOLD: begin
                    if (w_eff > r_duty)       w_next = S_RAMP_UP;
                    else if (w_eff < r_duty)  w_next = S_RAMP_DOWN;
                end
                S_STOP: if (w_eff == 4'd0) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_duty      <= '0;
            r_ramp_cnt  <= '0;
            r_at_target <= 1'b1;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_duty      <= w_duty_next;
            r_ramp_cnt  <= (w_clr_ramp || w_tick) ? '0 : r_ramp_cnt + 1'b1;
            r_at_target <= (w_next == S_IDLE) || (w_next == S_HOLD);
            r_busy      <= w_next_ramp;
            r_fault     <= (w_next == S_STOP);
        end
    end

    // Duty is latched only at the period boundary so no runt pulse appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_div <= '0;
            r_slot     <= '0;
            r_duty_lat <= '0;
            r_pwm      <= 1'b0;
        end else begin
            r_slot_div <= w_div_wrap ? '0 : r_slot_div + 1'b1;
            if (w_div_wrap) r_slot <= (r_slot == 4'd14) ? 4'd0 : r_slot + 4'd1;
            if (estop) begin
                r_duty_lat <= '0;
                r_pwm      <= 1'b0;
            end else begin
                if (w_period_end) r_duty_lat <= r_duty;
                r_pwm <= (r_slot < r_duty_lat);
            end
        end
    end

    assign motor_pwm = r_pwm;
    assign duty_now  = r_duty;
    assign at_target = r_at_target;
    assign busy      = r_busy;
    assign fault     = r_fault;

endmodule

// File: tb/tb_motor_ramp_pwm.sv
// Self-checking bench for motor_ramp_pwm against a cycle-level behavioural model
// of the duty slew, stop latch and period-aligned PWM.
module tb_motor_ramp_pwm;

    localparam int SLOT = 2;
    localparam int RAMP = 4;
    localparam int PER  = 15 * SLOT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] target = '0;
    logic       enable = 1'b0;
    logic       estop = 1'b0;
    logic       motor_pwm;
    logic [3:0] duty_now;
    logic       at_target, busy, fault;

    int checks = 0;
    int errors = 0;

    // Reference model: ramp direction (-1/0/+1), stopped flag, tick phase,
    // position within the PWM period, latched duty and PWM pin.
    int m_dir, m_cnt, m_duty, m_p, m_lat;
    bit m_stop, m_pwm;

    motor_ramp_pwm #(.SLOT_CYCLES(SLOT), .RAMP_CYCLES(RAMP)) dut (
        .clk(clk), .reset(reset), .target(target), .enable(enable), .estop(estop),
        .motor_pwm(motor_pwm), .duty_now(duty_now), .at_target(at_target),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dut_out();
        return {motor_pwm, duty_now, at_target, busy, fault};
    endfunction

    function automatic logic [7:0] m_out();
        logic [3:0] d;
        d = 4'(m_duty);
        return {m_pwm, d, (!m_stop && m_dir == 0), (m_dir != 0), m_stop};
    endfunction

    task automatic model_reset();
        m_dir = 0; m_cnt = 0; m_duty = 0; m_p = 0; m_lat = 0; m_stop = 0; m_pwm = 0;
    endtask

    task automatic model_edge();
        int eff, old_duty, old_lat;
        bit tick;
        eff      = enable ? int'(target) : 0;
        old_duty = m_duty;
        old_lat  = m_lat;
        if (estop) begin
            m_stop = 1; m_dir = 0; m_duty = 0; m_lat = 0; m_pwm = 0;
        end else begin
            m_pwm = ((m_p / SLOT) < old_lat);
            if (m_p == PER - 1) m_lat = old_duty;
            if (m_stop) begin
                if (eff == 0) m_stop = 0;
            end else if (m_dir == 0) begin
                if (eff > m_duty)      begin m_dir = 1;  m_cnt = 0; end
                else if (eff < m_duty) begin m_dir = -1; m_cnt = 0; end
            end else begin
                tick  = (m_cnt == RAMP - 1);
                m_cnt = (m_cnt + 1) % RAMP;
                if (eff == m_duty) m_dir = 0;
                else if (eff > m_duty) begin
                    if (m_dir == 1 && tick) m_duty++;
                    m_dir = 1;
                end else begin
                    if (m_dir == -1 && tick) m_duty--;
                    m_dir = -1;
                end
            end
        end
        m_p = (m_p + 1) % PER;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_out() !== 8'b0_0000_1_0_0) begin
            errors++; $display("FAIL reset_state got=%b exp=%b", dut_out(), 8'b0_0000_1_0_0);
        end
        reset = 1'b0;
        cyc();
        checks++;
        if (dut_out() !== m_out()) begin
            errors++; $display("FAIL reset_idle got=%b exp=%b", dut_out(), m_out());
        end
    endtask

    task automatic test_ramp_up();
        int highs;
        target = 4'd9; enable = 1'b1;
        for (int i = 1; i <= 38; i++) begin
            cyc();
            checks++;
            if (dut_out() !== m_out()) begin
                errors++; $display("FAIL ramp_up_cyc%0d got=%b exp=%b", i, dut_out(), m_out());
            end
            if (i == 37) begin
                checks++;
                if (duty_now !== 4'd9 || busy !== 1'b1) begin
                    errors++; $display("FAIL ramp_up_reach duty=%0d busy=%b exp duty=9 busy=1", duty_now, busy);
                end
            end
        end
        checks++;
        if (at_target !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ramp_up_hold at_target=%b busy=%b exp 1 0", at_target, busy);
        end
        repeat (60) cyc();
        highs = 0;
        for (int i = 0; i < PER; i++) begin cyc(); highs += int'(motor_pwm); end
        checks++;
        if (highs != 18) begin
            errors++; $display("FAIL pwm_duty9 highs=%0d exp=18", highs);
        end
    endtask

    task automatic test_ramp_down();
        int highs;
        target = 4'd3;
        for (int i = 1; i <= 26; i++) begin
            cyc();
            checks++;
            if (dut_out() !== m_out()) begin
                errors++; $display("FAIL ramp_down_cyc%0d got=%b exp=%b", i, dut_out(), m_out());
            end
            if (i == 25) begin
                checks++;
                if (duty_now !== 4'd3 || busy !== 1'b1) begin
                    errors++; $display("FAIL ramp_down_reach duty=%0d busy=%b exp duty=3 busy=1", duty_now, busy);
                end
            end
        end
        checks++;
        if (at_target !== 1'b1) begin
            errors++; $display("FAIL ramp_down_hold at_target=%b exp=1", at_target);
        end
        repeat (60) cyc();
        highs = 0;
        for (int i = 0; i < PER; i++) begin cyc(); highs += int'(motor_pwm); end
        checks++;
        if (highs != 6) begin
            errors++; $display("FAIL pwm_duty3 highs=%0d exp=6", highs);
        end
    endtask

    task automatic test_reversal();
        int n, prev, first;
        target = 4'd9;
        n = 0;
        while (duty_now != 4'd5 && n < 60) begin cyc(); n++; end
        checks++;
        if (duty_now !== 4'd5) begin
            errors++; $display("FAIL reversal_reach5 timeout duty=%0d exp=5", duty_now);
        end
        target = 4'd2;
        prev = 5; first = -1; n = 0;
        do begin
            cyc(); n++;
            checks++;
            if (dut_out() !== m_out() || (int'(duty_now) - prev) > 1 || (prev - int'(duty_now)) > 1) begin
                errors++; $display("FAIL reversal_cyc%0d got=%b exp=%b prev_duty=%0d", n, dut_out(), m_out(), prev);
            end
            if (first < 0 && int'(duty_now) != prev) first = int'(duty_now);
            prev = int'(duty_now);
        end while (!(at_target === 1'b1) && n < 60);
        checks++;
        if (first != 4 || duty_now !== 4'd2 || at_target !== 1'b1) begin
            errors++; $display("FAIL reversal_end first_step=%0d duty=%0d at_target=%b exp 4 2 1", first, duty_now, at_target);
        end
    endtask

    task automatic test_estop();
        int n;
        target = 4'd12;
        n = 0;
        while (duty_now != 4'd12 && n < 100) begin cyc(); n++; end
        checks++;
        if (duty_now !== 4'd12) begin
            errors++; $display("FAIL estop_reach12 timeout duty=%0d exp=12", duty_now);
        end
        estop = 1'b1;
        cyc();
        estop = 1'b0;
        checks++;
        if ({motor_pwm, duty_now, fault} !== {1'b0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL estop_edge pwm=%b duty=%0d fault=%b exp 0 0 1", motor_pwm, duty_now, fault);
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (dut_out() !== m_out() || fault !== 1'b1) begin
                errors++; $display("FAIL estop_latched_cyc%0d got=%b exp=%b", i, dut_out(), m_out());
            end
        end
        target = 4'd0;
        cyc();
        checks++;
        if (fault !== 1'b0 || at_target !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL estop_rearm fault=%b at_target=%b busy=%b exp 0 1 0", fault, at_target, busy);
        end
    endtask

    task automatic test_enable_off();
        int n, highs;
        target = 4'd15; enable = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!(at_target === 1'b1 && duty_now == 4'd15) && n < 100);
        checks++;
        if (duty_now !== 4'd15 || at_target !== 1'b1) begin
            errors++; $display("FAIL full_reach duty=%0d at_target=%b exp 15 1", duty_now, at_target);
        end
        repeat (60) cyc();
        highs = 0;
        for (int i = 0; i < PER; i++) begin cyc(); highs += int'(motor_pwm); end
        checks++;
        if (highs != PER) begin
            errors++; $display("FAIL pwm_duty15 highs=%0d exp=%0d", highs, PER);
        end
        enable = 1'b0;
        n = 0;
        do begin
            cyc(); n++;
            checks++;
            if (dut_out() !== m_out()) begin
                errors++; $display("FAIL disable_cyc%0d got=%b exp=%b", n, dut_out(), m_out());
            end
        end while (!(at_target === 1'b1) && n < 100);
        checks++;
        if (duty_now !== 4'd0 || at_target !== 1'b1) begin
            errors++; $display("FAIL disable_idle duty=%0d at_target=%b exp 0 1", duty_now, at_target);
        end
        repeat (PER) cyc();
        highs = 0;
        for (int i = 0; i < PER; i++) begin cyc(); highs += int'(motor_pwm); end
        checks++;
        if (highs != 0) begin
            errors++; $display("FAIL pwm_duty0 highs=%0d exp=0", highs);
        end
    endtask

    task automatic test_async_reset();
        int n;
        target = 4'd9; enable = 1'b1;
        n = 0;
        while (duty_now != 4'd7 && n < 60) begin cyc(); n++; end
        checks++;
        if (duty_now !== 4'd7) begin
            errors++; $display("FAIL areset_reach7 timeout duty=%0d exp=7", duty_now);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({motor_pwm, duty_now, at_target, busy} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL areset_immediate got=%b exp=%b", dut_out(), 8'b0_0000_1_0_0);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            checks++;
            if (dut_out() !== m_out()) begin
                errors++; $display("FAIL areset_restart_cyc%0d got=%b exp=%b", i, dut_out(), m_out());
            end
        end
        checks++;
        if (duty_now !== 4'd2) begin
            errors++; $display("FAIL areset_from_zero duty=%0d exp=2", duty_now);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int k = 0; k < 60; k++) begin
            target = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 5) != 0);
            hold   = $urandom_range(1, 40);
            for (int i = 0; i < hold; i++) begin
                estop = ($urandom_range(0, 60) == 0);
                cyc();
                checks++;
                if (dut_out() !== m_out()) begin
                    errors++; $display("FAIL random_k%0d_i%0d got=%b exp=%b", k, i, dut_out(), m_out());
                end
            end
        end
        estop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_reversal();
        test_estop();
        test_enable_off();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
